// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default data width
// and the sequencer state encoding.
package mul_pkg;

  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: per-requester valid/ready
// accept handshake, packed operands, one-hot response pulse and shared result.
interface mul_share_arbiter_if import mul_pkg::*; #(
  parameter int N       = MUL_W,
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [N-1:0]         resp_out;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_out, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_out, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int PW = $clog2(NUM_REQ);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[PW'(k)]) begin
        grant[PW'(k)] = 1'b1;
        idx           = PW'(k);
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one registered multiplier among NUM_REQ requesters: round-robin
// accept, operand latch, LAT-cycle wait, product capture, one-hot response.
module mul_share_arbiter import mul_pkg::*; #(
  parameter int N       = MUL_W,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_arbiter_if.slave  bus,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [N-1:0]        mul_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LAT + 1);

  state_t             state, state_nx;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      own;
  logic [PW-1:0]      g_idx;
  logic [NUM_REQ-1:0] g_hot;
  logic               g_any;
  logic [CW-1:0]      cnt;
  logic [N-1:0]       op_a, op_b;
  logic [N-1:0]       resp_q;
  logic [NUM_REQ-1:0] resp_v;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (g_hot),
    .idx   (g_idx),
    .any   (g_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state, accept strobe (only offered in IDLE) and busy flag.
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = g_hot;
        if (g_any) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
        if (cnt == CW'(1)) state_nx = ST_CAPT;
      end
      ST_CAPT: begin
        bus.busy = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: operand/owner latch on accept, wait countdown, product capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      own    <= '0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      resp_q <= '0;
      resp_v <= '0;
    end else begin
      resp_v <= '0;
      unique case (state)
        ST_IDLE: begin
          if (g_any) begin
            op_a   <= bus.req_a[32'(g_idx) * N +: N];
            op_b   <= bus.req_b[32'(g_idx) * N +: N];
            own    <= g_idx;
            rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
            cnt    <= CW'(LAT);
          end
        end
        ST_WAIT: cnt <= cnt - CW'(1);
        ST_CAPT: begin
          resp_q <= mul_out;
          resp_v <= NUM_REQ'(1) << own;
        end
        default: ;
      endcase
    end
  end

  assign mul_a          = op_a;
  assign mul_b          = op_b;
  assign bus.resp_out   = resp_q;
  assign bus.resp_valid = resp_v;

`ifndef SYNTHESIS
  // Handshake sanity: at most one grant, at most one response, no grant without a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(bus.req_ready)) else $error("req_ready not one-hot");
      assert ($onehot0(bus.resp_valid)) else $error("resp_valid not one-hot");
      assert ((bus.req_ready & ~bus.req_valid) == '0) else $error("grant without request");
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized + directed bench for mul_share_arbiter with a registered 16x16
// multiplier (LAT=1). A negedge monitor predicts grants and responses from
// an operation-level model and checks them against a response queue.
module tb_mul_share_arbiter;

  localparam int N   = 16;
  localparam int NR  = 4;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] mul_a, mul_b, mul_out;
  logic [31:0]  prod;

  mul_share_arbiter_if #(.N(N), .NUM_REQ(NR)) bus ();

  mul_share_arbiter #(.N(N), .NUM_REQ(NR), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_out (mul_out)
  );

  // Registered multiplier with its own async reset.
  assign prod = mul_a * mul_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mul_out <= '0;
    else      mul_out <= prod[N-1:0];
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int          owner;
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          ptr       = 0;
  int          free_cyc  = 0;
  logic [15:0] last_resp = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_out", 32'(bus.resp_out), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        q.delete();
        ptr       = 0;
        free_cyc  = cyc;
        last_resp = '0;
      end else begin
        logic [NR-1:0] exp_rv, exp_rd;
        int            g;
        exp_rv = '0;
        if (q.size() > 0 && q[0].due == cyc) exp_rv = NR'(1) << q[0].owner;
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        if (exp_rv != '0) begin
          last_resp = q[0].val;
          void'(q.pop_front());
        end
        check("resp_out", 32'(bus.resp_out), 32'(last_resp));
        check("busy", 32'(bus.busy), 32'(cyc < free_cyc));
        exp_rd = '0;
        g      = 0;
        if (cyc >= free_cyc) begin
          for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (ptr + k) % NR;
            if (exp_rd == '0 && bus.req_valid[idx]) begin
              exp_rd = NR'(1) << idx;
              g      = idx;
            end
          end
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_rd));
        if (exp_rd != '0) begin
          exp_t e;
          int unsigned p;
          p       = int'(bus.req_a[g*N +: N]) * int'(bus.req_b[g*N +: N]);
          e.owner = g;
          e.val   = p[15:0];
          e.due   = cyc + LAT + 2;
          q.push_back(e);
          ptr      = (g + 1) % NR;
          free_cyc = cyc + LAT + 2;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]     = v;
    bus.req_a[i*N +: N]  = a;
    bus.req_b[i*N +: N]  = b;
  endtask

  function automatic logic [15:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    case (r[2:0])
      3'd0:    return 16'h0000;
      3'd1:    return 16'hFFFF;
      default: return r[31:16];
    endcase
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Watchdog: the run is cycle-bounded, this only guards against a stuck sim.
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    cycle();

    // 1: single request, 258*258 truncates to 1028 after three cycles.
    set_req(0, 1'b1, 16'd258, 16'd258);
    #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
    cycle();
    set_req(0, 1'b0, 16'd0, 16'd0);
    cycle();
    cycle();
    check("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("t1_resp_out", 32'(bus.resp_out), 32'd1028);
    idle(2);

    // 2: all four held; grants 0,1,2,3,0 at three-cycle spacing.
    set_req(0, 1'b1, 16'd2, 16'd3);
    set_req(1, 1'b1, 16'd5, 16'd4);
    set_req(2, 1'b1, 16'd10, 16'd10);
    set_req(3, 1'b1, 16'd15, 16'd2);
    idle(13);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'd0, 16'd0);
    idle(5);

    // 3: after a grant to 1 the pointer sits at 2, so 0011 wraps to 0.
    set_req(1, 1'b1, 16'd3, 16'd3);
    cycle();
    set_req(1, 1'b0, 16'd0, 16'd0);
    idle(2);
    set_req(0, 1'b1, 16'd6, 16'd7);
    set_req(1, 1'b1, 16'd8, 16'd9);
    #1 check("t3_wrap", 32'(bus.req_ready), 32'h1);
    cycle();
    set_req(0, 1'b0, 16'd0, 16'd0);
    idle(3);
    set_req(1, 1'b0, 16'd0, 16'd0);
    idle(5);

    // 4: requester 2 re-issues in the cycle its response pulses.
    set_req(2, 1'b1, 16'd7, 16'd9);
    cycle();
    set_req(2, 1'b0, 16'd0, 16'd0);
    cycle();
    cycle();
    check("t4_first_resp", 32'(bus.resp_valid), 32'h4);
    set_req(2, 1'b1, 16'd32767, 16'd2);
    #1 check("t4_same_cycle_ready", 32'(bus.req_ready), 32'h4);
    cycle();
    set_req(2, 1'b0, 16'd0, 16'd0);
    cycle();
    cycle();
    check("t4_resp_valid", 32'(bus.resp_valid), 32'h4);
    check("t4_resp_out", 32'(bus.resp_out), 32'd65534);
    idle(3);

    // 5: reset during WAIT aborts the operation.
    set_req(0, 1'b1, 16'd128, 16'd256);
    cycle();
    set_req(0, 1'b0, 16'd0, 16'd0);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_busy_reset", 32'(bus.busy), 32'd0);
    check("t5_resp_valid_reset", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    cycle();
    idle(4);
    check("t5_resp_out_after", 32'(bus.resp_out), 32'd0);
    set_req(3, 1'b1, 16'h0123, 16'd0);
    cycle();
    set_req(3, 1'b0, 16'd0, 16'd0);
    idle(4);

    // 6: a one-cycle request while busy is never granted.
    set_req(0, 1'b1, 16'd3, 16'd3);
    cycle();
    set_req(0, 1'b0, 16'd0, 16'd0);
    set_req(3, 1'b1, 16'd1, 16'd1);
    #1 check("t6_ready", 32'(bus.req_ready), 32'd0);
    cycle();
    set_req(3, 1'b0, 16'd0, 16'd0);
    idle(5);

    // Random traffic: requests hold until accepted, with occasional drops
    // and back-to-back re-issue; operands scrambled after accept.
    for (int c = 0; c < 1500; c++) begin
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, rnd_op(), rnd_op());
          else                           set_req(i, 1'b0, rnd_op(), rnd_op());
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, rnd_op(), rnd_op());
        end else if ($urandom_range(0, 19) == 0) begin
          set_req(i, 1'b0, rnd_op(), rnd_op());
        end
      end
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'd0, 16'd0);
    idle(8);
    check("drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
